// File: rtl/noc_port_arbiter.sv
// rtl/noc_port_arbiter.sv - round-robin NoC output-port arbiter with a registered output stage
module noc_port_arbiter #(
  parameter int WIDTH = 34,
  parameter int NREQ  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  input  logic                  out_ready,
  output logic [2:0]            grant_id,
  output logic [15:0]           fwd_count
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] grant;
  logic          any_req;
  logic          load_en;
  logic          up_xfer;
  logic          down_xfer;

  // Round-robin search: the lowest offset from rr_ptr (with wrap) that is requesting wins.
  always_comb begin : rr_search
    int j;
    grant   = '0;
    any_req = 1'b0;
    j       = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = (int'(rr_ptr) + k) % NREQ;
      if (req_valid[j]) begin
        grant   = PW'(j);
        any_req = 1'b1;
      end
    end
  end

  // Handshake qualifiers and the one-hot accept back to the granted requester.
  always_comb begin
    load_en   = !out_valid || out_ready;
    up_xfer   = !rst && load_en && any_req;
    down_xfer = out_valid && out_ready;
    req_ready = '0;
    if (up_xfer) begin
      req_ready[grant] = 1'b1;
    end
  end

  // Output register, grant bookkeeping and delivery counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      grant_id  <= '0;
      fwd_count <= '0;
      rr_ptr    <= '0;
    end else begin
      if (down_xfer) begin
        fwd_count <= fwd_count + 16'd1;
      end
      if (up_xfer) begin
        out_valid <= 1'b1;
        out_data  <= req_data[int'(grant)*WIDTH +: WIDTH];
        grant_id  <= 3'(grant);
        rr_ptr    <= (grant == PW'(NREQ - 1)) ? '0 : grant + PW'(1);
      end else if (down_xfer) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_noc_port_arbiter.sv
// tb/tb_noc_port_arbiter.sv - self-checking bench for noc_port_arbiter against a behavioural model
module tb_noc_port_arbiter;

  localparam int WIDTH = 34;
  localparam int NREQ  = 5;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_data;
  logic                  out_ready;
  logic [2:0]            grant_id;
  logic [15:0]           fwd_count;

  noc_port_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .grant_id  (grant_id),
    .fwd_count (fwd_count)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state: what the output register should hold, whose turn it is, packets delivered.
  bit               m_ov;
  logic [WIDTH-1:0] m_data;
  int               m_gid;
  int               m_rr;
  int               m_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] model_ready();
    int g;
    g = model_grant(req_valid, m_rr);
    if (rst || g < 0 || (m_ov && !out_ready)) return '0;
    return NREQ'(1) << g;
  endfunction

  task automatic set_port(input int p, input logic [WIDTH-1:0] v);
    req_data[p*WIDTH +: WIDTH] = v;
  endtask

  task automatic rand_data();
    for (int p = 0; p < NREQ; p++) begin
      set_port(p, WIDTH'({$urandom(), $urandom()}));
    end
  endtask

  // Check the DUT against the model, clock once, then advance the model with the pre-edge inputs.
  task automatic step(input string tag);
    int g;
    bit up;
    bit down;
    #1;
    chk({tag, ".req_ready"}, 64'(req_ready), 64'(model_ready()));
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(m_ov));
    if (m_ov) begin
      chk({tag, ".out_data"}, 64'(out_data), 64'(m_data));
      chk({tag, ".grant_id"}, 64'(grant_id), 64'(m_gid));
    end
    chk({tag, ".fwd_count"}, 64'(fwd_count), 64'(m_cnt));
    @(posedge clk);
    g = model_grant(req_valid, m_rr);
    if (rst) begin
      m_ov = 0; m_data = '0; m_gid = 0; m_rr = 0; m_cnt = 0;
    end else begin
      up   = (g >= 0) && (!m_ov || out_ready);
      down = m_ov && out_ready;
      if (down) m_cnt = (m_cnt + 1) % 65536;
      if (up) begin
        m_data = req_data[g*WIDTH +: WIDTH];
        m_gid  = g;
        m_ov   = 1;
        m_rr   = (g + 1) % NREQ;
      end else if (down) begin
        m_ov = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = NREQ'($urandom());
    out_ready = 1'($urandom());
    rand_data();
    step("reset");
    rst = 1'b0;
    chk("reset.out_valid", 64'(out_valid), 64'(0));
    chk("reset.out_data", 64'(out_data), 64'(0));
    chk("reset.grant_id", 64'(grant_id), 64'(0));
    chk("reset.fwd_count", 64'(fwd_count), 64'(0));
  endtask

  initial begin
    int exp_order [7];
    logic [WIDTH-1:0] held;
    int base;

    rst = 1'b1; req_valid = '0; req_data = '0; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    m_ov = 0; m_data = '0; m_gid = 0; m_rr = 0; m_cnt = 0;

    // Single request from port 2
    do_reset();
    req_valid = 5'b00100; out_ready = 1'b1; rand_data();
    set_port(2, 34'h0_DEAD_BEEF);
    #1 chk("single.req_ready", 64'(req_ready), 64'(5'b00100));
    step("single.c0");
    chk("single.out_valid", 64'(out_valid), 64'(1));
    chk("single.out_data", 64'(out_data), 64'(34'h0_DEAD_BEEF));
    chk("single.grant_id", 64'(grant_id), 64'(2));
    req_valid = '0;
    step("single.c1");
    chk("single.fwd_count", 64'(fwd_count), 64'(1));

    // Round-robin fairness with every port requesting
    do_reset();
    exp_order = '{0, 1, 2, 3, 4, 0, 1};
    req_valid = '1; out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      rand_data();
      #1 chk("rr.req_ready", 64'(req_ready), 64'(NREQ'(1) << exp_order[i]));
      step("rr");
      chk("rr.grant_id", 64'(grant_id), 64'(exp_order[i]));
      chk("rr.out_valid", 64'(out_valid), 64'(1));
    end

    // Backpressure while a packet from port 1 is held
    do_reset();
    req_valid = 5'b00010; out_ready = 1'b1; rand_data();
    held = req_data[1*WIDTH +: WIDTH];
    step("bp.load");
    base = fwd_count;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_valid = '1; rand_data();
      #1 chk("bp.req_ready", 64'(req_ready), 64'(0));
      chk("bp.out_data", 64'(out_data), 64'(held));
      chk("bp.grant_id", 64'(grant_id), 64'(1));
      step("bp.stall");
    end
    req_valid = '0; out_ready = 1'b1;
    chk("bp.final_data", 64'(out_data), 64'(held));
    step("bp.drain");
    chk("bp.count", 64'(fwd_count), 64'(base + 1));
    chk("bp.empty", 64'(out_valid), 64'(0));

    // Skip: pointer lands on 3, only port 1 requests, pointer must move to 2
    do_reset();
    req_valid = 5'b00100; out_ready = 1'b1; rand_data();
    step("skip.p2");
    req_valid = 5'b00010; rand_data();
    step("skip.p1");
    chk("skip.grant_id", 64'(grant_id), 64'(1));
    req_valid = 5'b00110; rand_data();
    #1 chk("skip.ptr_is_2", 64'(req_ready), 64'(5'b00100));
    step("skip.after");

    // Counter wrap from 65535
    req_valid = '0; out_ready = 1'b1;
    step("wrap.idle0");
    step("wrap.idle1");
    force dut.fwd_count = 16'hFFFF;
    m_cnt = 65535;
    step("wrap.forced");
    release dut.fwd_count;
    chk("wrap.pre", 64'(fwd_count), 64'(16'hFFFF));
    req_valid = 5'b00001; rand_data();
    step("wrap.load");
    req_valid = '0;
    step("wrap.deliver");
    chk("wrap.fwd_count", 64'(fwd_count), 64'(0));

    // Reset during a stall
    req_valid = 5'b01000; out_ready = 1'b1; rand_data();
    step("rs.load");
    out_ready = 1'b0; req_valid = 5'b10101;
    step("rs.stall");
    rst = 1'b1;
    step("rs.reset");
    rst = 1'b0;
    chk("rs.out_valid", 64'(out_valid), 64'(0));
    chk("rs.fwd_count", 64'(fwd_count), 64'(0));
    req_valid = 5'b01010; out_ready = 1'b1;
    #1 chk("rs.lowest", 64'(req_ready), 64'(5'b00010));
    step("rs.next");

    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 49) == 0);
      req_valid = NREQ'($urandom());
      out_ready = ($urandom_range(0, 3) != 0);
      rand_data();
      step("rand");
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
